// File: rtl/button_ce_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_ce_gen
// Brief    : Debounced push-button to one-cycle clock-enable, with auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module button_ce_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic pulse,
    output logic repeat_active
);

    localparam int c_DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_DLW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam int c_PW  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam int c_RW  = (c_DLW > c_PW) ? c_DLW : c_PW;

    localparam logic [c_DW-1:0] c_DB_LAST    = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DB_ONE     = c_DW'(1);
    localparam logic [c_RW-1:0] c_DELAY_LAST = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_PER_LAST   = c_RW'(REPEAT_PERIOD - 1);
    localparam logic [c_RW-1:0] c_RCNT_ONE   = c_RW'(1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_HOLD_DELAY  = 2'd1;
    localparam logic [1:0] c_HOLD_REPEAT = 2'd2;

    logic            r_s1;
    logic            r_s2;
    logic [c_DW-1:0] r_dcnt;
    logic [c_RW-1:0] r_rcnt;
    logic [1:0]      r_state;
    logic            w_flip;
    logic            w_rise;

    // The FSM reacts to the flip in the same edge the debouncer commits it,
    // so the first pulse lines up with the first cycle of level=1.
    assign w_flip = (r_s2 != level) && (r_dcnt == c_DB_LAST);
    assign w_rise = w_flip && !level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= 1'b0;
            r_dcnt <= '0;
        end else if (r_s2 == level) begin
            r_dcnt <= '0;
        end else if (w_flip) begin
            level  <= r_s2;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + c_DB_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_rcnt        <= '0;
            pulse         <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        pulse   <= 1'b1;
                        r_rcnt  <= '0;
                        r_state <= c_HOLD_DELAY;
                    end
                end
                c_HOLD_DELAY: begin
                    if (!level) begin
                        r_state <= c_IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rcnt == c_DELAY_LAST) begin
                            pulse         <= 1'b1;
                            r_rcnt        <= '0;
                            r_state       <= c_HOLD_REPEAT;
                            repeat_active <= 1'b1;
                        end else begin
                            r_rcnt <= r_rcnt + c_RCNT_ONE;
                        end
                    end
                end
                c_HOLD_REPEAT: begin
                    if (!level) begin
                        r_state       <= c_IDLE;
                        r_rcnt        <= '0;
                        repeat_active <= 1'b0;
                    end else if (r_rcnt == c_PER_LAST) begin
                        pulse  <= 1'b1;
                        r_rcnt <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + c_RCNT_ONE;
                    end
                end
                default: begin
                    r_state       <= c_IDLE;
                    r_rcnt        <= '0;
                    repeat_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_ce_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_ce_gen
// Brief    : Self-checking bench for button_ce_gen (repeat on / repeat off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_ce_gen;

    localparam int D  = 4;
    localparam int DL = 8;
    localparam int PR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic lvl_r, pul_r, ra_r;
    logic lvl_o, pul_o, ra_o;

    always #5 clk = ~clk;

    button_ce_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(DL), .REPEAT_PERIOD(PR)) u_rep (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(lvl_r), .pulse(pul_r), .repeat_active(ra_r)
    );

    button_ce_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(DL), .REPEAT_PERIOD(PR)) u_one (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(lvl_o), .pulse(pul_o), .repeat_active(ra_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the debounced level flips when the synchronised input
    // (btn_in two edges back) has disagreed with it on each of the last D
    // edges since the previous flip/reset; pulses are a function of press age.
    logic bh [16];
    int   last_rst = 0;
    int   last_ev  = 0;
    logic m_lvl = 1'b0;
    logic m_sess [2];
    int   m_p    [2];
    logic m_pul  [2];
    logic m_ra   [2];
    bit   m_ok = 1'b0;

    function automatic logic s2pre(input int k);
        if (k - 2 > last_rst) return bh[(k - 2) % 16];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic prev;
        logic flip;
        int   k;
        int   age;
        cyc = cyc + 1;
        k = cyc;
        bh[k % 16] = btn_in;
        if (rst) begin
            last_rst = k;
            last_ev  = k;
            m_lvl    = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_sess[i] = 1'b0; m_pul[i] = 1'b0; m_ra[i] = 1'b0; m_p[i] = 0;
            end
            m_ok = 1'b1;
        end else begin
            prev = m_lvl;
            flip = 1'b1;
            for (int j = k - D + 1; j <= k; j++)
                if (j <= last_ev || s2pre(j) == prev) flip = 1'b0;
            if (flip) begin
                m_lvl   = !prev;
                last_ev = k;
            end
            for (int i = 0; i < 2; i++) begin
                m_pul[i] = 1'b0;
                m_ra[i]  = 1'b0;
                if (m_sess[i]) begin
                    if (!prev) begin
                        m_sess[i] = 1'b0;
                    end else begin
                        age = k - m_p[i];
                        if (i == 0 && age >= DL) begin
                            m_ra[i] = 1'b1;
                            if ((age - DL) % PR == 0) m_pul[i] = 1'b1;
                        end
                    end
                end else if (!prev && m_lvl) begin
                    m_sess[i] = 1'b1;
                    m_p[i]    = k;
                    m_pul[i]  = 1'b1;
                end
            end
        end
    end

    logic last_pul_r = 1'b0;
    logic last_pul_o = 1'b0;
    always @(negedge clk) begin
        if (m_ok) begin
            check("level_rep", lvl_r, m_lvl);
            check("level_one", lvl_o, m_lvl);
            check("pulse_rep", pul_r, m_pul[0]);
            check("pulse_one", pul_o, m_pul[1]);
            check("ract_rep", ra_r, m_ra[0]);
            check("ract_one", ra_o, m_ra[1]);
            check("pulse_gap_rep", pul_r && last_pul_r, 0);
            check("pulse_gap_one", pul_o && last_pul_o, 0);
            last_pul_r = pul_r;
            last_pul_o = pul_o;
        end
    end

    // Downstream consumers: a pulse counter and a modulo-7 counter on ce=pulse.
    int   np_one = 0;
    int   mod7   = 0;
    logic ctr_clr = 1'b0;
    always @(posedge clk) begin
        if (pul_o) np_one <= np_one + 1;
        if (ctr_clr) mod7 <= 0;
        else if (pul_o) mod7 <= (mod7 == 6) ? 0 : mod7 + 1;
    end

    task automatic goto_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e, r, s, b, base;
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", lvl_r, 0);
        check("rst_pulse", pul_r, 0);
        check("rst_ract", ra_r, 0);
        rst = 1'b0;
        goto_edge(cyc + 3);

        // Clean press and hold: single pulse (u_one), auto-repeat (u_rep).
        base = np_one;
        btn_in = 1'b1;
        e = cyc + 1;
        goto_edge(e + 4);  check("press_lvl_early", lvl_o, 0);
        goto_edge(e + 5);  check("press_lvl", lvl_o, 1);
                           check("press_pulse_one", pul_o, 1);
                           check("press_pulse_rep", pul_r, 1);
        goto_edge(e + 6);  check("press_pulse_end", pul_o, 0);
        goto_edge(e + 12); check("ract_before", ra_r, 0);
        goto_edge(e + 13); check("rep1_pulse", pul_r, 1);
                           check("ract_rise", ra_r, 1);
        goto_edge(e + 16); check("rep2_pulse", pul_r, 1);
        goto_edge(e + 19); check("rep3_pulse", pul_r, 1);
        goto_edge(e + 35); check("one_pulse_count", np_one - base, 1);
                           check("one_ract", ra_o, 0);

        // Release from HOLD_REPEAT, then re-press.
        btn_in = 1'b0;
        r = cyc + 1;
        goto_edge(r + 4); check("rel_lvl_held", lvl_r, 1);
        goto_edge(r + 5); check("rel_lvl_fall", lvl_r, 0);
        goto_edge(r + 6); check("rel_ract_off", ra_r, 0);
                          check("rel_no_pulse", pul_r, 0);
        goto_edge(r + 12);
        btn_in = 1'b1;
        e = cyc + 1;
        goto_edge(e + 5); check("repress_pulse_rep", pul_r, 1);
                          check("repress_pulse_one", pul_o, 1);
        btn_in = 1'b0;
        goto_edge(cyc + 15);

        // Bounce: 1 x3, 0 x2, then steady 1.
        base = np_one;
        btn_in = 1'b1;
        b = cyc + 1;
        goto_edge(b + 2);
        btn_in = 1'b0;
        goto_edge(b + 4);
        btn_in = 1'b1;
        s = cyc + 1;
        goto_edge(s + 4);  check("bounce_lvl_early", lvl_o, 0);
        goto_edge(s + 5);  check("bounce_lvl", lvl_o, 1);
                           check("bounce_pulse", pul_o, 1);
        goto_edge(s + 15); check("bounce_pulse_count", np_one - base, 1);
                           check("bounce_in_repeat", ra_r, 1);

        // Reset in the middle of auto-repeat with the button still held.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_level", lvl_r, 0);
        check("midrst_pulse", pul_r, 0);
        check("midrst_ract", ra_r, 0);
        rst = 1'b0;
        r = cyc;
        goto_edge(r + 5); check("postrst_lvl_early", lvl_r, 0);
        goto_edge(r + 6); check("postrst_lvl", lvl_r, 1);
                          check("postrst_pulse", pul_r, 1);

        // Nine presses into a modulo-7 counter.
        btn_in = 1'b0;
        goto_edge(cyc + 12);
        ctr_clr = 1'b1;
        @(posedge clk);
        #1;
        ctr_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            btn_in = 1'b1;
            goto_edge(cyc + 12);
            btn_in = 1'b0;
            goto_edge(cyc + 12);
        end
        check("mod7_count", mod7, 2);

        // Random bouncing with occasional resets, checked against the model.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            btn_in = 1'($urandom_range(0, 1));
            goto_edge(cyc + int'($urandom_range(1, 25)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_ce_gen.md
Name: button_ce_gen

Overview:
- Turns a raw, bouncing, asynchronous push-button into a clean one-cycle clock-enable pulse.
- Sits directly upstream of the modulo-N counter and drives its ce input: one counter step per press.
- Holding the button auto-repeats: first pulse on press, another after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
- Also exports the debounced level and a repeat-active flag for LEDs or status.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must differ from level before level flips (10 ms @ 100 MHz); >=1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives exactly one pulse per press.
- REPEAT_DELAY, 50000000, cycles from the first pulse to the first repeat pulse; >=2.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; >=2.
- Counter widths: $clog2 of each count parameter, minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw button, asynchronous, active-high, may bounce.
- level  output  1  debounced button state, registered.
- pulse  output  1  one-cycle clock enable for the downstream counter, registered.
- repeat_active  output  1  high while in the HOLD_REPEAT state.

Behaviour:
- Reset (rst=1 at a clock edge): sync flops, level, pulse, repeat_active, all counters -> 0; state -> IDLE. Reset wins over all other events, including mid-debounce and mid-repeat.
- Synchroniser: s1<=btn_in; s2<=s1. Only s2 is used downstream.
- Debounce, each edge:
  - if s2==level: dcnt<=0.
  - else if dcnt==DEBOUNCE_CYCLES-1: level<=s2, dcnt<=0.
  - else dcnt<=dcnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: btn_in change sampled at edge E -> level changes at edge E+DEBOUNCE_CYCLES+1. Same rule for press and release.
- Pulse FSM uses the current (pre-edge) registered level. The "rise" condition means the debouncer flips level 0->1 at this edge. pulse defaults to 0 every edge unless set below.
  - IDLE: on rise -> pulse<=1, rcnt<=0, go to HOLD_DELAY. The first pulse coincides with the first cycle level=1.
  - HOLD_DELAY, if level==0 -> IDLE.
  - HOLD_DELAY, else if REPEAT_EN==0 -> stay; rcnt frozen.
  - HOLD_DELAY, else if rcnt==REPEAT_DELAY-1 -> pulse<=1, rcnt<=0, go to HOLD_REPEAT.
  - HOLD_DELAY, else -> rcnt<=rcnt+1.
  - HOLD_REPEAT, if level==0 -> IDLE, rcnt<=0.
  - HOLD_REPEAT, else if rcnt==REPEAT_PERIOD-1 -> pulse<=1, rcnt<=0.
  - HOLD_REPEAT, else -> rcnt<=rcnt+1.
  - repeat_active is registered: 1 exactly while state==HOLD_REPEAT.
- Pulse timing: first pulse at edge P. Repeats at P+REPEAT_DELAY, then +REPEAT_PERIOD each time. pulse is never high on two consecutive cycles.
- Release at the same edge a repeat expires: the FSM sees the old level=1, so the pulse still fires; the next edge goes to IDLE.
- Release never produces a pulse.
- A new press is accepted only from IDLE, i.e. after a debounced release.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3; btn_in change first sampled at edge E):
- Clean press, hold 30 cycles, REPEAT_EN=0 -> level and pulse rise at E+5; pulse high exactly 1 cycle; no further pulses; repeat_active stays 0.
- Bounce: btn_in 1 for 3 cycles, 0 for 2, then steady 1 -> no level change during bounce; level rises 5 edges after the steady-1 sample; exactly one pulse.
- Auto-repeat, REPEAT_EN=1, hold -> pulses at E+5, E+13, E+16, E+19; repeat_active rises at E+13.
- Release: drop btn_in sampled at edge R while in HOLD_REPEAT -> level falls at R+5; state IDLE at R+6; no pulse on release. Re-press gives a fresh first pulse after the 5-edge debounce.
- Reset mid-repeat: rst=1 for one edge during HOLD_REPEAT with button held -> all outputs 0. After rst release the held button re-debounces: level and pulse rise 5 edges after rst deasserts.
- Chain with modulo-7 counter (ce=pulse): 9 separate debounced presses -> counter reads 2.
